// File: rtl/mem_read_cmd_engine_if.sv
// Bundles the command, AXI4 read, result stream and status channels of the read engine.
// The master modport is the engine's view; slave is the view of everything around it.
interface mem_read_cmd_engine_if #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 512
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [63:0]             cmd_address;
  logic [31:0]             cmd_length;

  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic [5:0]              m_axi_arid;

  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;

  logic                    m_axis_valid;
  logic                    m_axis_ready;
  logic [DATA_WIDTH-1:0]   m_axis_data;
  logic [DATA_WIDTH/8-1:0] m_axis_keep;
  logic                    m_axis_last;

  logic                    sts_valid;
  logic                    sts_ready;
  logic [7:0]              sts_data;

  modport master (
    input  cmd_valid, cmd_address, cmd_length,
    output cmd_ready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output m_axi_rready,
    output m_axis_valid, m_axis_data, m_axis_keep, m_axis_last,
    input  m_axis_ready,
    output sts_valid, sts_data,
    input  sts_ready
  );

  modport slave (
    output cmd_valid, cmd_address, cmd_length,
    input  cmd_ready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  m_axi_rready,
    input  m_axis_valid, m_axis_data, m_axis_keep, m_axis_last,
    output m_axis_ready,
    input  sts_valid, sts_data,
    output sts_ready
  );
endinterface

// File: rtl/mem_read_cmd_engine.sv
// Splits one byte-granular read command into 4 KB-safe AXI4 INCR bursts and forwards
// the returned beats unbuffered as a keep/last-qualified stream, then reports status.
module mem_read_cmd_engine #(
  parameter int ADDR_WIDTH      = 34,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BEATS       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                   clk,
  input logic                   rst,
  mem_read_cmd_engine_if.master bus
);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_STATUS = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [31:0]           len_q;
  logic [26:0]           total_q;
  logic [26:0]           remaining_q;
  logic [26:0]           beat_cnt_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  arvalid_q;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic                  bad_q;
  logic                  err_q;

  logic                  in_run;
  logic                  ar_hs, r_hs, rlast_hs, final_beat, last_hs;
  logic                  cmd_bad, can_issue;
  logic [26:0]           total_calc;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [26:0]           burst_rem;
  logic [6:0]            to_boundary;
  logic [6:0]            burst_beats;
  logic [KEEP_W-1:0]     tail_keep;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.cmd_address[63:ADDR_WIDTH];

  assign in_run     = (state_q == S_RUN);
  assign ar_hs      = arvalid_q && bus.m_axi_arready;
  assign r_hs       = in_run && bus.m_axi_rvalid && bus.m_axis_ready;
  assign rlast_hs   = r_hs && bus.m_axi_rlast;
  assign final_beat = (beat_cnt_q == total_q - 27'd1);
  assign last_hs    = r_hs && final_beat;

  assign cmd_bad    = (len_q == 32'd0) || (cmd_addr_q[5:0] != 6'd0);
  assign total_calc = {1'b0, len_q[31:6]} + {26'd0, |len_q[5:0]};

  // The first burst is sized while still in CHECK so arvalid can rise on the RUN entry cycle.
  assign burst_addr  = (state_q == S_CHECK) ? cmd_addr_q : next_addr_q;
  assign burst_rem   = (state_q == S_CHECK) ? total_calc : remaining_q;
  assign to_boundary = 7'd64 - {1'b0, burst_addr[11:6]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    burst_beats = to_boundary;
    if (7'(MAX_BEATS) < burst_beats) burst_beats = 7'(MAX_BEATS);
    if (burst_rem < {20'd0, burst_beats}) burst_beats = burst_rem[6:0];
  end

  always_comb begin
    outst_d = outst_q;
    if (ar_hs && !rlast_hs)      outst_d = outst_q + OUT_W'(1);
    else if (!ar_hs && rlast_hs) outst_d = outst_q - OUT_W'(1);
  end

  // A new burst may be loaded in the same cycle the previous one is accepted.
  assign can_issue = (remaining_q != 27'd0) && (!arvalid_q || ar_hs) &&
                     (outst_d < OUT_W'(MAX_OUTSTANDING));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = S_CHECK;
      S_CHECK:  state_d = cmd_bad ? S_STATUS : S_RUN;
      S_RUN:    if (last_hs) state_d = S_STATUS;
      S_STATUS: if (bus.sts_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_addr_q  <= '0;
      len_q       <= '0;
      total_q     <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      next_addr_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      outst_q     <= '0;
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_addr_q <= bus.cmd_address[ADDR_WIDTH-1:0];
            len_q      <= bus.cmd_length;
            beat_cnt_q <= '0;
            bad_q      <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        S_CHECK: begin
          bad_q   <= cmd_bad;
          total_q <= total_calc;
          if (!cmd_bad) begin
            arvalid_q   <= 1'b1;
            araddr_q    <= burst_addr;
            arlen_q     <= {1'b0, burst_beats - 7'd1};
            next_addr_q <= burst_addr + ADDR_WIDTH'({burst_beats, 6'd0});
            remaining_q <= burst_rem - {20'd0, burst_beats};
          end
        end
        S_RUN: begin
          if (can_issue) begin
            arvalid_q   <= 1'b1;
            araddr_q    <= burst_addr;
            arlen_q     <= {1'b0, burst_beats - 7'd1};
            next_addr_q <= burst_addr + ADDR_WIDTH'({burst_beats, 6'd0});
            remaining_q <= burst_rem - {20'd0, burst_beats};
          end else if (ar_hs) begin
            arvalid_q <= 1'b0;
          end
          if (r_hs) beat_cnt_q <= beat_cnt_q + 27'd1;
          if (r_hs && bus.m_axi_rresp != 2'b00) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tail_keep = ({{(KEEP_W-1){1'b0}}, 1'b1} << len_q[5:0]) - KEEP_W'(1);

  assign bus.cmd_ready     = (state_q == S_IDLE) && !rst;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'd6;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arid    = 6'd0;

  assign bus.m_axi_rready  = in_run && bus.m_axis_ready;
  assign bus.m_axis_valid  = in_run && bus.m_axi_rvalid;
  assign bus.m_axis_data   = bus.m_axi_rdata;
  assign bus.m_axis_keep   = (final_beat && len_q[5:0] != 6'd0) ? tail_keep : '1;
  assign bus.m_axis_last   = in_run && final_beat;

  assign bus.sts_valid     = (state_q == S_STATUS);
  assign bus.sts_data      = (state_q == S_STATUS) ? {5'd0, err_q, bad_q, 1'b1} : 8'd0;
endmodule

// File: tb/tb_mem_read_cmd_engine.sv
// Bench for mem_read_cmd_engine: a memory-slave model feeds the AXI side while a
// burst/stream reference model built from address arithmetic predicts every output.
`timescale 1ns/1ps
module tb_mem_read_cmd_engine;
  localparam int AW = 34;
  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_read_cmd_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_read_cmd_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(64), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;
  typedef struct {
    logic [63:0] addr; logic [31:0] len; int err_beat;
    int ar_mode; int r_mode; int s_mode;
    logic [7:0] exp_sts; int exp_n_ar; logic [AW-1:0] exp_ar0_addr; logic [7:0] exp_ar0_len;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Environment state shared between the slave process and the test sequence.
  int    cyc = 0;
  int    ar_mode = 0, r_mode = 0, s_mode = 0, err_beat = -1;
  ar_t   ar_log[$];
  ar_t   r_pend[$];
  int    ar_cyc[$];
  beat_t got[$];
  int    r_beat = 0, cmd_r_beats = 0;
  bit    r_stall = 0;
  int    n_accept = 0, n_sts = 0, sts_base = 0;
  int    accept_cyc = -1, first_ar_cyc = -1, sts_cyc = -1, last_beat_cyc = -1, first_rlast_cyc = -1;
  logic [7:0] sts_got = 8'd0;
  bit    mirror_bad = 0, ready_bad = 0;

  ar_t   exp_ar[$];
  beat_t exp_beats[$];
  logic [7:0] exp_sts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int j = 0; j < 16; j++) d[32*j +: 32] = {a[33:6], 4'(j)};
    return d;
  endfunction

  // Reference: burst list and stream beats from the command, using plain integer arithmetic.
  task automatic build_model(input logic [63:0] a, input logic [31:0] l, input int errb);
    longint unsigned mask, base, cur, n, rem, b, room;
    mask = (64'd1 << AW) - 64'd1;
    exp_ar.delete();
    exp_beats.delete();
    if (l == 0 || a[5:0] != 6'd0) begin
      exp_sts = 8'h03;
      return;
    end
    base = a & mask;
    n    = (longint'(l) + 63) / 64;
    rem  = n;
    cur  = base;
    while (rem > 0) begin
      room = (4096 - (cur % 4096)) / 64;
      b = rem;
      if (b > 64) b = 64;
      if (b > room) b = room;
      exp_ar.push_back('{AW'(cur), 8'(b - 1)});
      cur = (cur + b * 64) & mask;
      rem = rem - b;
    end
    for (longint unsigned i = 0; i < n; i++) begin
      beat_t e;
      e.data = mem_data(AW'((base + i * 64) & mask));
      e.last = (i == n - 1);
      e.keep = '1;
      if (i == n - 1 && (l % 64) != 0) begin
        e.keep = '0;
        for (int k = 0; k < int'(l % 64); k++) e.keep[k] = 1'b1;
      end
      exp_beats.push_back(e);
    end
    exp_sts = 8'h01 | ((errb >= 0 && longint'(errb) < longint'(n)) ? 8'h04 : 8'h00);
  endtask

  // Memory slave and stream/status sink: drive on the falling edge, observe 1 ns later.
  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axis_ready  = 1'b0;
    bus.sts_ready     = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        r_pend.delete();
        r_beat  = 0;
        r_stall = 0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_arready = 1'b0;
        continue;
      end
      bus.m_axi_arready = (ar_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!r_stall) begin
        if (r_pend.size() > 0 && (r_mode == 0 || (r_mode == 1 && $urandom_range(0, 2) != 0))) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata  = mem_data(r_pend[0].addr + AW'(r_beat * 64));
          bus.m_axi_rlast  = (r_beat == int'(r_pend[0].len));
          bus.m_axi_rresp  = (cmd_r_beats == err_beat) ? 2'b10 : 2'b00;
        end else begin
          bus.m_axi_rvalid = 1'b0;
          bus.m_axi_rdata  = {16{$urandom}};
          bus.m_axi_rlast  = 1'b0;
          bus.m_axi_rresp  = 2'b00;
        end
      end
      bus.m_axis_ready = (s_mode == 0) ? 1'b1 :
                         (s_mode == 1) ? 1'($urandom_range(0, 1)) : 1'((cyc % 2) == 1);
      bus.sts_ready    = ($urandom_range(0, 2) == 0);
      #1;
      if (bus.cmd_valid && bus.cmd_ready) begin
        accept_cyc = cyc;
        n_accept++;
      end
      if (bus.m_axi_arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_log.push_back('{bus.m_axi_araddr, bus.m_axi_arlen});
        r_pend.push_back('{bus.m_axi_araddr, bus.m_axi_arlen});
        ar_cyc.push_back(cyc);
      end
      if (bus.m_axis_valid && (bus.m_axi_rready != bus.m_axis_ready)) mirror_bad = 1;
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        r_stall = 0;
        cmd_r_beats++;
        if (bus.m_axi_rlast) begin
          void'(r_pend.pop_front());
          r_beat = 0;
          if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
        end else begin
          r_beat++;
        end
      end else begin
        r_stall = bus.m_axi_rvalid;
      end
      if (bus.m_axis_valid && bus.m_axis_ready) begin
        got.push_back('{bus.m_axis_data, bus.m_axis_keep, bus.m_axis_last});
        last_beat_cyc = cyc;
      end
      if (bus.sts_valid) begin
        if (bus.cmd_ready) ready_bad = 1;
        if (sts_cyc < 0) sts_cyc = cyc;
      end
      if (bus.sts_valid && bus.sts_ready) begin
        sts_got = bus.sts_data;
        n_sts++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_cmd(input logic [63:0] a, input logic [31:0] l);
    int n0;
    int w;
    @(negedge clk);
    ar_log.delete(); got.delete(); ar_cyc.delete();
    first_ar_cyc = -1; sts_cyc = -1; last_beat_cyc = -1; first_rlast_cyc = -1;
    cmd_r_beats = 0; mirror_bad = 0; ready_bad = 0;
    sts_base = n_sts;
    n0 = n_accept;
    bus.cmd_valid   = 1'b1;
    bus.cmd_address = a;
    bus.cmd_length  = l;
    #2;
    w = 0;
    while (n_accept == n0 && w < 20) begin
      @(negedge clk); #2; w++;
    end
    check("cmd_accept", n_accept != n0, 1);
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    bus.cmd_address = {$urandom, $urandom};
    bus.cmd_length  = $urandom;
  endtask

  task automatic wait_sts(input int budget, input string tag);
    int w;
    w = 0;
    while (n_sts == sts_base && w < budget) begin
      @(negedge clk); #2; w++;
    end
    check({tag, ":done"}, n_sts != sts_base, 1);
    if (n_sts == sts_base) do_reset();
  endtask

  task automatic compare_cmd(input string tag);
    int nbad;
    check({tag, ":sts"}, sts_got, exp_sts);
    check({tag, ":n_ar"}, ar_log.size(), exp_ar.size());
    nbad = 0;
    for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++)
      if (ar_log[i].addr !== exp_ar[i].addr || ar_log[i].len !== exp_ar[i].len) nbad++;
    check({tag, ":ar_list"}, nbad, 0);
    check({tag, ":n_beats"}, got.size(), exp_beats.size());
    nbad = 0;
    for (int i = 0; i < got.size() && i < exp_beats.size(); i++)
      if (got[i].data !== exp_beats[i].data || got[i].keep !== exp_beats[i].keep ||
          got[i].last !== exp_beats[i].last) nbad++;
    check({tag, ":beats"}, nbad, 0);
    check({tag, ":rready_mirror"}, mirror_bad, 0);
    check({tag, ":cmd_ready_in_sts"}, ready_bad, 0);
    if (exp_sts[1]) begin
      check({tag, ":sts_latency"}, sts_cyc - accept_cyc, 2);
    end else begin
      check({tag, ":ar_latency"}, first_ar_cyc - accept_cyc, 2);
      check({tag, ":sts_after_last"}, sts_cyc - last_beat_cyc, 1);
    end
  endtask

  task automatic exec(input vec_t v, input string tag);
    ar_mode = v.ar_mode; r_mode = v.r_mode; s_mode = v.s_mode; err_beat = v.err_beat;
    build_model(v.addr, v.len, v.err_beat);
    start_cmd(v.addr, v.len);
    wait_sts(4000, tag);
    compare_cmd(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   w;
    string tag;

    bus.cmd_valid = 1'b0;
    bus.cmd_address = '0;
    bus.cmd_length = '0;

    //           addr                    len   errb ar r  s  sts    nar ar0_addr     ar0_len
    tbl[0] = '{64'h1000,                 256,  -1,  0, 0, 0, 8'h01, 1,  34'h1000,    8'd3};
    tbl[1] = '{64'h0F80,                 200,  -1,  1, 1, 1, 8'h01, 2,  34'h0F80,    8'd1};
    tbl[2] = '{64'h0,                    0,    -1,  0, 0, 0, 8'h03, 0,  34'h0,       8'd0};
    tbl[3] = '{64'h1004,                 64,   -1,  0, 0, 0, 8'h03, 0,  34'h0,       8'd0};
    tbl[4] = '{64'h2000,                 200,  1,   0, 0, 2, 8'h05, 1,  34'h2000,    8'd3};
    tbl[5] = '{64'h40,                   4480, -1,  1, 1, 1, 8'h01, 2,  34'h40,      8'd62};
    tbl[6] = '{64'h0000_0004_0000_7FC0,  1,    -1,  0, 0, 1, 8'h01, 1,  34'h7FC0,    8'd0};

    #1 rst = 1'b1;
    #11;
    check("rst:cmd_ready", bus.cmd_ready, 0);
    check("rst:arvalid", bus.m_axi_arvalid, 0);
    check("rst:sts_valid", bus.sts_valid, 0);
    check("rst:sts_data", bus.sts_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    check("idle:cmd_ready", bus.cmd_ready, 1);
    check("const:arsize", bus.m_axi_arsize, 3'd6);
    check("const:arburst", bus.m_axi_arburst, 2'b01);
    check("const:arid", bus.m_axi_arid, 6'd0);

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("tbl%0d", i);
      exec(tbl[i], tag);
      check({tag, ":tbl_sts"}, sts_got, tbl[i].exp_sts);
      check({tag, ":tbl_n_ar"}, ar_log.size(), tbl[i].exp_n_ar);
      if (tbl[i].exp_n_ar > 0) begin
        check({tag, ":tbl_ar0_addr"}, (ar_log.size() > 0) ? ar_log[0].addr : '1, tbl[i].exp_ar0_addr);
        check({tag, ":tbl_ar0_len"}, (ar_log.size() > 0) ? ar_log[0].len : 8'hFF, tbl[i].exp_ar0_len);
      end
    end

    // Outstanding limit: 64 KB from 0 with R held off stops after eight full bursts.
    ar_mode = 0; r_mode = 2; s_mode = 0; err_beat = -1;
    build_model(64'h0, 32'd65536, -1);
    start_cmd(64'h0, 32'd65536);
    repeat (40) @(negedge clk);
    #2;
    check("outst:ar_count_held", ar_log.size(), 8);
    check("outst:arvalid_low", bus.m_axi_arvalid, 0);
    w = 0;
    foreach (ar_log[i]) if (ar_log[i].len != 8'd63) w++;
    check("outst:arlen_63", w, 0);
    r_mode = 0;
    wait_sts(4000, "outst");
    check("outst:ar9_after_rlast",
          (ar_cyc.size() > 8) ? ar_cyc[8] - first_rlast_cyc : -1, 1);
    compare_cmd("outst");

    // Reset in the middle of RUN, then a clean command.
    ar_mode = 0; r_mode = 0; s_mode = 0; err_beat = -1;
    start_cmd(64'h3000, 32'd512);
    w = 0;
    while (got.size() < 2 && w < 50) begin
      @(negedge clk); #2; w++;
    end
    check("rstrun:two_beats", got.size() >= 2, 1);
    rst = 1'b1;
    #1;
    check("rstrun:cmd_ready", bus.cmd_ready, 0);
    check("rstrun:arvalid", bus.m_axi_arvalid, 0);
    check("rstrun:rready", bus.m_axi_rready, 0);
    check("rstrun:axis_valid", bus.m_axis_valid, 0);
    check("rstrun:axis_last", bus.m_axis_last, 0);
    check("rstrun:sts_valid", bus.sts_valid, 0);
    check("rstrun:sts_data", bus.sts_data, 0);
    check("rstrun:araddr", bus.m_axi_araddr, 0);
    check("rstrun:arlen", bus.m_axi_arlen, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exec(tbl[0], "after_rst");

    // Randomized commands against the reference model.
    for (int i = 0; i < 25; i++) begin
      v.addr = {$urandom, $urandom};
      v.addr[5:0] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      v.len = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 4000));
      v.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : -1;
      v.ar_mode = int'($urandom_range(0, 1));
      v.r_mode = int'($urandom_range(0, 1));
      v.s_mode = int'($urandom_range(0, 2));
      v.exp_sts = 8'h00; v.exp_n_ar = 0; v.exp_ar0_addr = '0; v.exp_ar0_len = 8'h00;
      exec(v, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
